// File: rtl/conv2d3x3_strided.sv
// Strided 3x3 signed convolution engine on AXI4-Stream with channel-chunked input,
// an internal kernel buffer, wide accumulators and shift+saturate requantisation.
module conv2d3x3_strided #(
    parameter int IN_HEIGHT        = 8,
    parameter int IN_WIDTH         = 8,
    parameter int IN_CHANNEL       = 4,
    parameter int WORDS            = 2,
    parameter int WORD_WIDTH       = 8,
    parameter int FILTERS          = 8,
    parameter int KERNEL_BUF_WIDTH = 32,
    parameter int STRIDE           = 1,
    parameter int ACC_WIDTH        = 24,
    parameter int OUT_SHIFT        = 0,
    localparam int TPP             = IN_CHANNEL / WORDS,
    localparam int FPL             = KERNEL_BUF_WIDTH / (WORDS * WORD_WIDTH),
    localparam int GROUPS          = FILTERS / FPL
) (
    input  logic                          i_aclk,
    input  logic                          i_aresetn,
    input  logic                          i_tvalid,
    output logic                          o_tready,
    input  logic [WORDS*WORD_WIDTH-1:0]   i_tdata,
    input  logic                          i_kernel_tvalid,
    output logic                          o_kernel_tready,
    input  logic [KERNEL_BUF_WIDTH-1:0]   i_kernel_tdata,
    output logic                          o_tvalid,
    input  logic                          i_tready,
    output logic [FPL*WORD_WIDTH-1:0]     o_tdata,
    output logic                          o_tlast
);

    localparam int DW       = WORDS * WORD_WIDTH;
    localparam int LB_DEPTH = IN_WIDTH * TPP;
    localparam int KB_DEPTH = TPP * GROUPS * 9;
    localparam int ROW_W    = $clog2(IN_HEIGHT);
    localparam int COL_W    = $clog2(IN_WIDTH);
    localparam int CH_W     = (TPP > 1) ? $clog2(TPP) : 1;
    localparam int GRP_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int LB_W     = $clog2(LB_DEPTH);
    localparam int KPTR_W   = $clog2(KB_DEPTH);
    localparam int LAST_ROW = IN_HEIGHT - 1 - ((IN_HEIGHT - 3) % STRIDE);
    localparam int LAST_COL = IN_WIDTH - 1 - ((IN_WIDTH - 3) % STRIDE);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (WORD_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_ACCEPT,
        S_MAC,
        S_OUT
    } state_t;

    state_t                         r_state;
    state_t                         w_nextState;

    logic [ROW_W-1:0]               r_row;
    logic [COL_W-1:0]               r_col;
    logic [CH_W-1:0]                r_ch;
    logic [CH_W-1:0]                r_macCh;
    logic [GRP_W-1:0]               r_group;
    logic                           r_lastWin;

    logic                           r_kernelValid;
    logic                           r_kernelReady;
    logic [KPTR_W-1:0]              r_kWrPtr;

    logic [DW-1:0]                  r_lb0    [LB_DEPTH];
    logic [DW-1:0]                  r_lb1    [LB_DEPTH];
    logic [DW-1:0]                  r_win    [TPP][9];
    logic [KERNEL_BUF_WIDTH-1:0]    r_kernel [KB_DEPTH];
    logic signed [ACC_WIDTH-1:0]    r_acc    [FILTERS];

    logic signed [ACC_WIDTH-1:0]    w_partial [FPL];
    logic                           w_hs;
    logic                           w_rowOk;
    logic                           w_colOk;
    logic                           w_winValid;
    logic                           w_lastPos;
    logic                           w_chLast;
    logic                           w_colLast;
    logic                           w_rowLast;
    logic                           w_groupLast;
    logic [LB_W-1:0]                w_lbIdx;
    logic [KPTR_W-1:0]              w_kBase;

    function automatic logic signed [ACC_WIDTH-1:0] mulExt(
        input logic signed [WORD_WIDTH-1:0] a,
        input logic signed [WORD_WIDTH-1:0] b
    );
        logic signed [2*WORD_WIDTH-1:0] p;
        p = a * b;
        return {{(ACC_WIDTH - 2*WORD_WIDTH){p[2*WORD_WIDTH-1]}}, p};
    endfunction

    function automatic logic [WORD_WIDTH-1:0] satWord(input logic signed [ACC_WIDTH-1:0] a);
        logic signed [ACC_WIDTH-1:0] s;
        s = a >>> OUT_SHIFT;
        if (s > SAT_MAX)
            return SAT_MAX[WORD_WIDTH-1:0];
        else if (s < SAT_MIN)
            return SAT_MIN[WORD_WIDTH-1:0];
        else
            return s[WORD_WIDTH-1:0];
    endfunction

    // Window gating is purely counter based, so stale line-buffer columns never reach the MAC.
    assign w_rowOk     = (int'(r_row) >= 2) && (((int'(r_row) - 2) % STRIDE) == 0);
    assign w_colOk     = (int'(r_col) >= 2) && (((int'(r_col) - 2) % STRIDE) == 0);
    assign w_winValid  = w_rowOk && w_colOk;
    assign w_lastPos   = (int'(r_row) == LAST_ROW) && (int'(r_col) == LAST_COL);
    assign w_chLast    = (int'(r_ch) == TPP - 1);
    assign w_colLast   = (int'(r_col) == IN_WIDTH - 1);
    assign w_rowLast   = (int'(r_row) == IN_HEIGHT - 1);
    assign w_groupLast = (int'(r_group) == GROUPS - 1);
    assign w_lbIdx     = LB_W'(int'(r_col) * TPP + int'(r_ch));
    assign w_kBase     = KPTR_W'((int'(r_macCh) * GROUPS + int'(r_group)) * 9);
    assign w_hs        = i_tvalid && o_tready;

    assign o_kernel_tready = r_kernelReady;

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn)
            r_state <= S_ACCEPT;
        else
            r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        o_tready    = 1'b0;
        o_tvalid    = 1'b0;
        case (r_state)
            S_ACCEPT: begin
                o_tready = r_kernelValid;
                if (i_tvalid && r_kernelValid && w_winValid)
                    w_nextState = S_MAC;
            end
            S_MAC: begin
                if (w_groupLast)
                    w_nextState = (int'(r_macCh) == TPP - 1) ? S_OUT : S_ACCEPT;
            end
            S_OUT: begin
                o_tvalid = 1'b1;
                if (i_tready && w_groupLast)
                    w_nextState = S_ACCEPT;
            end
            default: w_nextState = S_ACCEPT;
        endcase
    end

    always_comb begin
        o_tdata = '0;
        o_tlast = 1'b0;
        if (r_state == S_OUT) begin
            for (int f = 0; f < FILTERS; f++) begin
                if ((f / FPL) == int'(r_group))
                    o_tdata[(f % FPL)*WORD_WIDTH +: WORD_WIDTH] = satWord(r_acc[f]);
            end
            o_tlast = r_lastWin && w_groupLast;
        end
    end

    // One group of FPL filters per MAC cycle: 9 taps x WORDS channels each.
    always_comb begin
        for (int i = 0; i < FPL; i++)
            w_partial[i] = '0;
        for (int i = 0; i < FPL; i++) begin
            for (int k = 0; k < 9; k++) begin
                for (int l = 0; l < WORDS; l++) begin
                    w_partial[i] = w_partial[i] + mulExt(
                        r_win[r_macCh][k][l*WORD_WIDTH +: WORD_WIDTH],
                        r_kernel[w_kBase + KPTR_W'(k)][(i*WORDS + l)*WORD_WIDTH +: WORD_WIDTH]);
                end
            end
        end
    end

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_row     <= '0;
            r_col     <= '0;
            r_ch      <= '0;
            r_macCh   <= '0;
            r_group   <= '0;
            r_lastWin <= 1'b0;
            for (int f = 0; f < FILTERS; f++)
                r_acc[f] <= '0;
        end else begin
            if (w_hs) begin
                r_macCh   <= r_ch;
                r_lastWin <= w_lastPos;
                if (w_chLast) begin
                    r_ch <= '0;
                    if (w_colLast) begin
                        r_col <= '0;
                        r_row <= w_rowLast ? '0 : r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end else begin
                    r_ch <= r_ch + 1'b1;
                end
            end
            case (r_state)
                S_MAC: begin
                    for (int f = 0; f < FILTERS; f++) begin
                        if ((f / FPL) == int'(r_group)) begin
                            if (r_macCh == '0)
                                r_acc[f] <= w_partial[f % FPL];
                            else
                                r_acc[f] <= r_acc[f] + w_partial[f % FPL];
                        end
                    end
                    r_group <= w_groupLast ? '0 : r_group + 1'b1;
                end
                S_OUT: begin
                    if (i_tready)
                        r_group <= w_groupLast ? '0 : r_group + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Kernel beats fill selections in order sel=ch*GROUPS+g, 9 taps each; the pointer wraps for reloads.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_kWrPtr      <= '0;
            r_kernelValid <= 1'b0;
            r_kernelReady <= 1'b0;
        end else begin
            r_kernelReady <= 1'b1;
            if (i_kernel_tvalid && r_kernelReady) begin
                if (int'(r_kWrPtr) == KB_DEPTH - 1) begin
                    r_kWrPtr      <= '0;
                    r_kernelValid <= 1'b1;
                end else begin
                    r_kWrPtr <= r_kWrPtr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_aclk) begin
        if (i_kernel_tvalid && r_kernelReady)
            r_kernel[r_kWrPtr] <= i_kernel_tdata;
        if (w_hs) begin
            r_lb0[w_lbIdx] <= r_lb1[w_lbIdx];
            r_lb1[w_lbIdx] <= i_tdata;
            for (int rr = 0; rr < 3; rr++) begin
                r_win[r_ch][rr*3 + 0] <= r_win[r_ch][rr*3 + 1];
                r_win[r_ch][rr*3 + 1] <= r_win[r_ch][rr*3 + 2];
            end
            r_win[r_ch][2] <= r_lb0[w_lbIdx];
            r_win[r_ch][5] <= r_lb1[w_lbIdx];
            r_win[r_ch][8] <= i_tdata;
        end
    end

endmodule

// File: tb/tb_conv2d3x3_strided.sv
// Scoreboard bench for conv2d3x3_strided: a plain-arithmetic convolution model feeds an
// expected-beat queue that an independent output monitor drains and compares.
module tb_conv2d3x3_strided;

    localparam int H        = 5;
    localparam int W        = 5;
    localparam int IC       = 4;
    localparam int WORDS    = 2;
    localparam int WW       = 8;
    localparam int FILTERS  = 4;
    localparam int KBW      = 32;
    localparam int STRIDE   = 2;
    localparam int ACC      = 24;
    localparam int SHIFT    = 4;
    localparam int TPP      = IC / WORDS;
    localparam int FPL      = KBW / (WORDS * WW);
    localparam int GROUPS   = FILTERS / FPL;
    localparam int KB_DEPTH = TPP * GROUPS * 9;
    localparam int DW       = WORDS * WW;

    typedef struct packed {
        logic [FPL*WW-1:0] data;
        logic              last;
    } beat_t;

    logic               clk = 1'b0;
    logic               rstN;
    logic               iTvalid;
    logic               oTready;
    logic [DW-1:0]      iTdata;
    logic               iKernelTvalid;
    logic               oKernelTready;
    logic [KBW-1:0]     iKernelTdata;
    logic               oTvalid;
    logic               iTready;
    logic [FPL*WW-1:0]  oTdata;
    logic               oTlast;

    beat_t              expQ[$];
    beat_t              monBeat;
    int                 img[H][W][IC];
    int                 kw[FILTERS][IC][3][3];
    int                 checks = 0;
    int                 errors = 0;
    bit                 monEnable   = 1'b0;
    bit                 randomReady = 1'b0;
    bit                 holdReady   = 1'b0;
    bit                 gapsOn      = 1'b0;
    bit                 stallPending = 1'b0;
    logic [FPL*WW-1:0]  stallData;
    logic               stallLast;

    conv2d3x3_strided #(
        .IN_HEIGHT(H), .IN_WIDTH(W), .IN_CHANNEL(IC), .WORDS(WORDS), .WORD_WIDTH(WW),
        .FILTERS(FILTERS), .KERNEL_BUF_WIDTH(KBW), .STRIDE(STRIDE), .ACC_WIDTH(ACC),
        .OUT_SHIFT(SHIFT)
    ) dut (
        .i_aclk          (clk),
        .i_aresetn       (rstN),
        .i_tvalid        (iTvalid),
        .o_tready        (oTready),
        .i_tdata         (iTdata),
        .i_kernel_tvalid (iKernelTvalid),
        .o_kernel_tready (oKernelTready),
        .i_kernel_tdata  (iKernelTdata),
        .o_tvalid        (oTvalid),
        .i_tready        (iTready),
        .o_tdata         (oTdata),
        .o_tlast         (oTlast)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int satRef(input int v);
        int s;
        int hi;
        s  = v >>> SHIFT;
        hi = (1 << (WW - 1)) - 1;
        if (s > hi) return hi;
        if (s < -hi - 1) return -hi - 1;
        return s;
    endfunction

    // Direct convolution over every strided window of the current image, in raster order.
    task automatic pushExpected();
        int    lastR;
        int    lastC;
        beat_t b;
        lastR = 2;
        while (lastR + STRIDE < H) lastR += STRIDE;
        lastC = 2;
        while (lastC + STRIDE < W) lastC += STRIDE;
        for (int r = 2; r < H; r += STRIDE) begin
            for (int c = 2; c < W; c += STRIDE) begin
                for (int g = 0; g < GROUPS; g++) begin
                    b.data = '0;
                    for (int i = 0; i < FPL; i++) begin
                        int sum;
                        sum = 0;
                        for (int ch = 0; ch < IC; ch++)
                            for (int kr = 0; kr < 3; kr++)
                                for (int kc = 0; kc < 3; kc++)
                                    sum += img[r-2+kr][c-2+kc][ch] * kw[g*FPL+i][ch][kr][kc];
                        b.data[i*WW +: WW] = WW'(satRef(sum));
                    end
                    b.last = (r == lastR) && (c == lastC) && (g == GROUPS - 1);
                    expQ.push_back(b);
                end
            end
        end
    endtask

    function automatic logic [DW-1:0] pixelWord(input int r, input int c, input int t);
        logic [DW-1:0] d;
        d = '0;
        for (int l = 0; l < WORDS; l++)
            d[l*WW +: WW] = WW'(img[r][c][t*WORDS+l]);
        return d;
    endfunction

    task automatic fillImage(input bit rnd, input int val);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                for (int ch = 0; ch < IC; ch++)
                    img[r][c][ch] = rnd ? (int'($urandom_range(0, 31)) - 16) : val;
    endtask

    task automatic fillKernels(input bit rnd, input int val);
        for (int f = 0; f < FILTERS; f++)
            for (int ch = 0; ch < IC; ch++)
                for (int kr = 0; kr < 3; kr++)
                    for (int kc = 0; kc < 3; kc++)
                        kw[f][ch][kr][kc] = rnd ? (int'($urandom_range(0, 31)) - 16) : val;
    endtask

    // Drives one data transfer, optionally after a random idle gap; waits are bounded.
    task automatic applyStimulus(input logic [DW-1:0] data);
        bit accepted;
        accepted = 1'b0;
        if (gapsOn && ($urandom_range(0, 3) == 0)) begin
            iTvalid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        iTvalid = 1'b1;
        iTdata  = data;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (oTready) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) checkOutput("input_accept_timeout", 64'(accepted), 64'd1);
        @(posedge clk);
        #1;
        iTvalid = 1'b0;
    endtask

    task automatic feedPixels(input int nPixels);
        for (int p = 0; p < nPixels; p++)
            for (int t = 0; t < TPP; t++)
                applyStimulus(pixelWord(p / W, p % W, t));
    endtask

    task automatic runImage();
        pushExpected();
        feedPixels(H * W);
    endtask

    task automatic loadKernels(input bit expectBlocked);
        logic [KBW-1:0] d;
        bit             seen;
        for (int idx = 0; idx < KB_DEPTH; idx++) begin
            int sel;
            int k;
            sel = idx / 9;
            k   = idx % 9;
            d   = '0;
            for (int i = 0; i < FPL; i++)
                for (int l = 0; l < WORDS; l++)
                    d[(i*WORDS+l)*WW +: WW] =
                        WW'(kw[(sel % GROUPS)*FPL+i][(sel / GROUPS)*WORDS+l][k/3][k%3]);
            iKernelTvalid = 1'b1;
            iKernelTdata  = d;
            seen = 1'b0;
            for (int n = 0; n < 100; n++) begin
                @(negedge clk);
                if (oKernelTready) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) checkOutput("kernel_ready_timeout", 64'(seen), 64'd1);
            if (expectBlocked) checkOutput("tready_before_kernels", 64'(oTready), 64'd0);
            @(posedge clk);
            #1;
        end
        iKernelTvalid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (expQ.size() == 0 && !oTvalid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) checkOutput("drain_timeout", 64'(expQ.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Output ready pattern is updated just after each rising edge.
    initial begin
        iTready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            iTready = holdReady ? 1'b0 : (randomReady ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // Monitor: compares accepted beats against the queue and checks stability while stalled.
    initial begin
        forever begin
            @(negedge clk);
            if (monEnable && rstN) begin
                if (stallPending) begin
                    stallPending = 1'b0;
                    checkOutput("stall_tvalid", 64'(oTvalid), 64'd1);
                    checkOutput("stall_tdata", 64'(oTdata), 64'(stallData));
                    checkOutput("stall_tlast", 64'(oTlast), 64'(stallLast));
                end
                if (oTvalid && iTready) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_beat", 64'(oTdata), 64'd0);
                        if (oTdata == '0) begin
                            errors++;
                            $display("[TB] FAIL unexpected_beat: got extra beat, expected none");
                        end
                    end else begin
                        monBeat = expQ.pop_front();
                        checkOutput("beat_tdata", 64'(oTdata), 64'(monBeat.data));
                        checkOutput("beat_tlast", 64'(oTlast), 64'(monBeat.last));
                    end
                end else if (oTvalid) begin
                    stallPending = 1'b1;
                    stallData    = oTdata;
                    stallLast    = oTlast;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN          = 1'b0;
        iTvalid       = 1'b0;
        iTdata        = '0;
        iKernelTvalid = 1'b0;
        iKernelTdata  = '0;
        #12;
        checkOutput("reset_tvalid", 64'(oTvalid), 64'd0);
        checkOutput("reset_tdata", 64'(oTdata), 64'd0);
        checkOutput("reset_tlast", 64'(oTlast), 64'd0);
        checkOutput("reset_tready", 64'(oTready), 64'd0);
        checkOutput("reset_kernel_tready", 64'(oKernelTready), 64'd0);
        @(posedge clk);
        #1;
        rstN      = 1'b1;
        monEnable = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] kernels absent: data must be held off until the last kernel beat");
        fillImage(1'b0, 127);
        fillKernels(1'b0, 127);
        iTvalid = 1'b1;
        iTdata  = pixelWord(0, 0, 0);
        loadKernels(1'b1);
        @(negedge clk);
        checkOutput("tready_after_kernels", 64'(oTready), 64'd1);
        iTvalid = 1'b0;
        @(posedge clk);
        #1;
        runImage();
        drain();

        $display("[TB] negative saturation and small non-saturating sums");
        fillKernels(1'b0, -128);
        loadKernels(1'b0);
        runImage();
        drain();
        fillImage(1'b0, 1);
        fillKernels(1'b0, 1);
        loadKernels(1'b0);
        runImage();
        drain();

        $display("[TB] random data, back-to-back images, random gaps and backpressure");
        fillKernels(1'b1, 0);
        loadKernels(1'b0);
        randomReady = 1'b1;
        gapsOn      = 1'b1;
        for (int n = 0; n < 3; n++) begin
            fillImage(1'b1, 0);
            runImage();
        end
        drain();
        randomReady = 1'b0;
        gapsOn      = 1'b0;

        $display("[TB] asynchronous reset while an output beat is stalled");
        holdReady = 1'b1;
        iTready   = 1'b0;
        fillImage(1'b1, 0);
        feedPixels(2 * W + 3);
        begin
            bit reached;
            reached = 1'b0;
            for (int n = 0; n < 50; n++) begin
                @(negedge clk);
                if (oTvalid) begin
                    reached = 1'b1;
                    break;
                end
            end
            checkOutput("out_reached_before_reset", 64'(reached), 64'd1);
        end
        repeat (3) @(negedge clk);
        monEnable = 1'b0;
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("midreset_tvalid", 64'(oTvalid), 64'd0);
        checkOutput("midreset_tdata", 64'(oTdata), 64'd0);
        checkOutput("midreset_tlast", 64'(oTlast), 64'd0);
        @(posedge clk);
        #1;
        rstN         = 1'b1;
        holdReady    = 1'b0;
        stallPending = 1'b0;
        monEnable    = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] rerun after reset with reloaded kernels");
        fillImage(1'b0, 127);
        fillKernels(1'b0, 127);
        loadKernels(1'b0);
        runImage();
        drain();
        fillKernels(1'b1, 0);
        loadKernels(1'b0);
        randomReady = 1'b1;
        fillImage(1'b1, 0);
        runImage();
        drain();
        randomReady = 1'b0;

        checkOutput("queue_empty_at_end", 64'(expQ.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
